// File: rtl/pio_shift_out.sv
// Serializes each new parallel PIO word MSB-first into a 74HC595-style chain, then strobes the latch.
// Latency: transfer starts on the first clk edge that sees a new word (or the post-reset refresh).
// No backpressure: words written while busy are coalesced; only the newest is sent afterwards.
`timescale 1ns/1ps
module pio_shift_out #(
    parameter int WIDTH   = 32,
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] par_in,
    output logic             ser_clk,
    output logic             ser_data,
    output logic             ser_latch,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BITS_FULL = CW'(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] last_sent, last_sent_nxt;
    logic [WIDTH-1:0] shift_reg, shift_nxt;
    logic [CW-1:0]    bit_cnt, bit_cnt_nxt;
    logic [DW-1:0]    div_cnt, div_nxt;
    logic             force_pend, force_pend_nxt;
    logic             ser_clk_nxt, ser_data_nxt, ser_latch_nxt, busy_nxt;
    logic [WIDTH-1:0] shifted;
    logic             div_end;

    assign shifted = shift_reg << 1;
    assign div_end = (div_cnt == DIV_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_sent  <= '0;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            force_pend <= 1'b1;
            ser_clk    <= 1'b0;
            ser_data   <= 1'b0;
            ser_latch  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_sent  <= last_sent_nxt;
            shift_reg  <= shift_nxt;
            bit_cnt    <= bit_cnt_nxt;
            div_cnt    <= div_nxt;
            force_pend <= force_pend_nxt;
            ser_clk    <= ser_clk_nxt;
            ser_data   <= ser_data_nxt;
            ser_latch  <= ser_latch_nxt;
            busy       <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_sent_nxt  = last_sent;
        shift_nxt      = shift_reg;
        bit_cnt_nxt    = bit_cnt;
        div_nxt        = div_cnt;
        force_pend_nxt = force_pend;
        ser_clk_nxt    = ser_clk;
        ser_data_nxt   = ser_data;
        ser_latch_nxt  = ser_latch;
        busy_nxt       = busy;

        case (state)
            IDLE: begin
                // par_in is only looked at here, so mid-transfer writes coalesce naturally
                if (par_in != last_sent || force_pend) begin
                    shift_nxt      = par_in;
                    last_sent_nxt  = par_in;
                    force_pend_nxt = 1'b0;
                    ser_data_nxt   = par_in[WIDTH-1];
                    bit_cnt_nxt    = BITS_FULL;
                    div_nxt        = '0;
                    busy_nxt       = 1'b1;
                    state_nxt      = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (div_end) begin
                    div_nxt     = '0;
                    ser_clk_nxt = 1'b1;
                    state_nxt   = SHIFT_HI;
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end
            SHIFT_HI: begin
                if (div_end) begin
                    div_nxt     = '0;
                    ser_clk_nxt = 1'b0;
                    bit_cnt_nxt = bit_cnt - 1'b1;
                    if (bit_cnt != CW'(1)) begin
                        // next bit appears with the falling shift clock: full half-period of setup
                        shift_nxt    = shifted;
                        ser_data_nxt = shifted[WIDTH-1];
                        state_nxt    = SHIFT_LO;
                    end else begin
                        ser_data_nxt  = 1'b0;
                        ser_latch_nxt = 1'b1;
                        state_nxt     = LATCH;
                    end
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end
            LATCH: begin
                if (div_end) begin
                    div_nxt       = '0;
                    ser_latch_nxt = 1'b0;
                    busy_nxt      = 1'b0;
                    state_nxt     = IDLE;
                end else begin
                    div_nxt = div_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pio_shift_out.sv
// Bench for pio_shift_out: a default instance plus a CLK_DIV=1 instance, observed from the pin side.
`timescale 1ns/1ps
module tb_pio_shift_out;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] par_a = 32'h0;
    logic [31:0] par_b = 32'h0;
    logic        ser_clk_a, ser_data_a, ser_latch_a, busy_a;
    logic        ser_clk_b, ser_data_b, ser_latch_b, busy_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pio_shift_out dut_a (
        .clk(clk), .reset_n(reset_n), .par_in(par_a),
        .ser_clk(ser_clk_a), .ser_data(ser_data_a), .ser_latch(ser_latch_a), .busy(busy_a)
    );

    pio_shift_out #(.WIDTH(32), .CLK_DIV(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .par_in(par_b),
        .ser_clk(ser_clk_b), .ser_data(ser_data_b), .ser_latch(ser_latch_b), .busy(busy_b)
    );

    // Pin-level view of the external chain: what the 595s would shift and latch.
    logic        a_sclk_q = 0, a_latch_q = 0, a_busy_q = 0, a_data_q = 0;
    logic [31:0] a_acc = 0;
    int a_bits = 0, a_busy_len = 0, a_latch_len = 0, a_gap = 0;
    int a_rises = 0, a_busy_cycles = 0, a_overlap = 0, a_hold_viol = 0;
    logic [31:0] a_words[$];
    int a_wbits[$], a_latch_lens[$], a_busy_lens[$], a_gaps[$];

    always @(negedge clk) begin
        if (!reset_n) begin
            a_acc <= 0; a_bits <= 0; a_busy_len <= 0; a_latch_len <= 0; a_gap <= 0;
            a_sclk_q <= 0; a_latch_q <= 0; a_busy_q <= 0; a_data_q <= 0;
        end else begin
            a_sclk_q <= ser_clk_a; a_latch_q <= ser_latch_a; a_busy_q <= busy_a; a_data_q <= ser_data_a;
            if (ser_clk_a && !a_sclk_q) begin
                a_acc   <= {a_acc[30:0], ser_data_a};
                a_bits  <= a_bits + 1;
                a_rises <= a_rises + 1;
            end
            if (ser_clk_a && ser_latch_a) a_overlap <= a_overlap + 1;
            if (ser_clk_a && a_sclk_q && ser_data_a !== a_data_q) a_hold_viol <= a_hold_viol + 1;
            if (busy_a) begin
                a_busy_len    <= a_busy_len + 1;
                a_busy_cycles <= a_busy_cycles + 1;
                if (!a_busy_q) a_gaps.push_back(a_gap);
            end else begin
                a_gap <= a_gap + 1;
            end
            if (!busy_a && a_busy_q) begin
                a_busy_lens.push_back(a_busy_len);
                a_busy_len <= 0;
                a_gap      <= 1;
            end
            if (ser_latch_a) a_latch_len <= a_latch_len + 1;
            if (!ser_latch_a && a_latch_q) begin
                a_words.push_back(a_acc);
                a_wbits.push_back(a_bits);
                a_latch_lens.push_back(a_latch_len);
                a_acc <= 0; a_bits <= 0; a_latch_len <= 0;
            end
        end
    end

    logic        b_sclk_q = 0, b_latch_q = 0, b_busy_q = 0;
    logic [31:0] b_acc = 0;
    int b_bits = 0, b_busy_len = 0, b_since = 0, b_period_bad = 0;
    logic [31:0] b_words[$];
    int b_wbits[$], b_busy_lens[$];

    always @(negedge clk) begin
        if (!reset_n) begin
            b_acc <= 0; b_bits <= 0; b_busy_len <= 0; b_since <= 0;
            b_sclk_q <= 0; b_latch_q <= 0; b_busy_q <= 0;
        end else begin
            b_sclk_q <= ser_clk_b; b_latch_q <= ser_latch_b; b_busy_q <= busy_b;
            if (ser_clk_b && !b_sclk_q) begin
                b_acc   <= {b_acc[30:0], ser_data_b};
                b_bits  <= b_bits + 1;
                b_since <= 0;
                if (b_bits > 0 && b_since + 1 != 2) b_period_bad <= b_period_bad + 1;
            end else begin
                b_since <= b_since + 1;
            end
            if (busy_b) b_busy_len <= b_busy_len + 1;
            if (!busy_b && b_busy_q) begin
                b_busy_lens.push_back(b_busy_len);
                b_busy_len <= 0;
            end
            if (!ser_latch_b && b_latch_q) begin
                b_words.push_back(b_acc);
                b_wbits.push_back(b_bits);
                b_acc <= 0; b_bits <= 0;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_quiet(input int budget, output bit ok);
        int quiet = 0;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (busy_a === 1'b0 && busy_b === 1'b0) quiet++;
            else quiet = 0;
            if (quiet >= 3) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 0; par_a = 32'hA5A50001; par_b = 32'hFFFF_FFFF;
        tick(2);
        n_tests++;
        if ({ser_clk_a, ser_data_a, ser_latch_a, busy_a} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_outputs: got %b want 0000", {ser_clk_a, ser_data_a, ser_latch_a, busy_a});
        end
        reset_n = 1;
        tick();
        n_tests++;
        if ({busy_a, ser_clk_a, ser_data_a, ser_latch_a} !== 4'b1010) begin
            n_fail++; $display("FAIL first_edge_start: got %b want 1010", {busy_a, ser_clk_a, ser_data_a, ser_latch_a});
        end
    endtask

    task automatic test_first_transfer;
        bit ok;
        wait_quiet(600, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL first_timeout: busy never settled"); end
        n_tests++;
        if (a_words.size() !== 1) begin n_fail++; $display("FAIL first_count: got %0d want 1", a_words.size()); end
        n_tests++;
        if (a_words[0] !== 32'hA5A50001) begin n_fail++; $display("FAIL first_word: got %h want a5a50001", a_words[0]); end
        n_tests++;
        if (a_wbits[0] !== 32) begin n_fail++; $display("FAIL first_bits: got %0d want 32", a_wbits[0]); end
        n_tests++;
        if (a_latch_lens[0] !== 4) begin n_fail++; $display("FAIL latch_len: got %0d want 4", a_latch_lens[0]); end
        n_tests++;
        if (a_busy_lens[0] !== 260) begin n_fail++; $display("FAIL busy_len: got %0d want 260", a_busy_lens[0]); end
        n_tests++;
        if (a_overlap !== 0) begin n_fail++; $display("FAIL clk_latch_overlap: got %0d want 0", a_overlap); end
        n_tests++;
        if (a_hold_viol !== 0) begin n_fail++; $display("FAIL data_hold: got %0d want 0", a_hold_viol); end
    endtask

    task automatic test_clkdiv1;
        n_tests++;
        if (b_words.size() < 1) begin n_fail++; $display("FAIL div1_count: got %0d want >=1", b_words.size()); end
        n_tests++;
        if (b_words[0] !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div1_word: got %h want ffffffff", b_words[0]); end
        n_tests++;
        if (b_wbits[0] !== 32) begin n_fail++; $display("FAIL div1_bits: got %0d want 32", b_wbits[0]); end
        n_tests++;
        if (b_busy_lens[0] !== 65) begin n_fail++; $display("FAIL div1_busy: got %0d want 65", b_busy_lens[0]); end
        n_tests++;
        if (b_period_bad !== 0) begin n_fail++; $display("FAIL div1_period: got %0d bad periods want 0", b_period_bad); end
    endtask

    task automatic test_hold;
        int r0 = a_rises, w0 = a_words.size(), c0 = a_busy_cycles;
        tick(1000);
        n_tests++;
        if (a_rises - r0 !== 0) begin n_fail++; $display("FAIL hold_sclk: got %0d edges want 0", a_rises - r0); end
        n_tests++;
        if (a_words.size() - w0 !== 0) begin n_fail++; $display("FAIL hold_latch: got %0d pulses want 0", a_words.size() - w0); end
        n_tests++;
        if (a_busy_cycles - c0 !== 0) begin n_fail++; $display("FAIL hold_busy: got %0d cycles want 0", a_busy_cycles - c0); end
    endtask

    task automatic test_back_to_back;
        bit ok;
        int w0 = a_words.size(), g0 = a_gaps.size();
        par_a = 32'h1;
        tick(30);
        par_a = 32'h2;
        tick(30);
        par_a = 32'h3;
        wait_quiet(1200, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL b2b_timeout: busy never settled"); end
        n_tests++;
        if (a_words.size() - w0 !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d want 2", a_words.size() - w0); end
        n_tests++;
        if (a_words[w0] !== 32'h1) begin n_fail++; $display("FAIL b2b_word0: got %h want 00000001", a_words[w0]); end
        n_tests++;
        if (a_words[w0+1] !== 32'h3) begin n_fail++; $display("FAIL b2b_word1: got %h want 00000003", a_words[w0+1]); end
        n_tests++;
        if (a_gaps[g0+1] !== 1) begin n_fail++; $display("FAIL b2b_gap: got %0d idle cycles want 1", a_gaps[g0+1]); end
    endtask

    task automatic test_reset_mid;
        bit ok = 0;
        int w0 = a_words.size();
        par_a = 32'h12345678;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (a_bits >= 10) begin ok = 1; break; end
        end
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL mid_reach_bit10: bit counter stuck at %0d", a_bits); end
        #1 reset_n = 0;
        #1;
        n_tests++;
        if ({ser_clk_a, ser_data_a, ser_latch_a, busy_a} !== 4'b0000) begin
            n_fail++; $display("FAIL mid_async_reset: got %b want 0000", {ser_clk_a, ser_data_a, ser_latch_a, busy_a});
        end
        tick(3);
        reset_n = 1;
        wait_quiet(800, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL mid_timeout: busy never settled"); end
        n_tests++;
        if (a_words.size() - w0 !== 1) begin n_fail++; $display("FAIL mid_count: got %0d want 1", a_words.size() - w0); end
        n_tests++;
        if (a_words[w0] !== 32'h12345678 || a_wbits[w0] !== 32) begin
            n_fail++; $display("FAIL mid_resend: got %h/%0d bits want 12345678/32", a_words[w0], a_wbits[w0]);
        end
    endtask

    task automatic test_toggle;
        bit ok;
        int w0;
        par_a = 32'h0F;
        wait_quiet(600, ok);
        w0 = a_words.size();
        par_a = 32'h0F; tick();
        par_a = 32'hF0; tick();
        par_a = 32'h0F;
        wait_quiet(1200, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL toggle_timeout: busy never settled"); end
        n_tests++;
        if (a_words.size() - w0 !== 2) begin n_fail++; $display("FAIL toggle_count: got %0d want 2", a_words.size() - w0); end
        n_tests++;
        if (a_words[w0] !== 32'hF0 || a_words[w0+1] !== 32'h0F) begin
            n_fail++; $display("FAIL toggle_words: got %h,%h want 000000f0,0000000f", a_words[w0], a_words[w0+1]);
        end
    endtask

    // Reference: the chain must end up receiving, in order, every value that differs from
    // the previous one sent, where only the value present when the link goes idle counts.
    task automatic test_random;
        bit ok;
        logic [31:0] model_last = 32'h0F;
        logic [31:0] exp_q[$];
        logic [31:0] v;
        int w0 = a_words.size();
        for (int it = 0; it < 6; it++) begin
            v = $urandom;
            if (it == 2) v = model_last;
            par_a = v;
            if (v != model_last) begin
                exp_q.push_back(v);
                model_last = v;
                for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
                    tick($urandom_range(5, 40));
                    par_a = ($urandom_range(0, 3) == 0) ? model_last : $urandom;
                end
            end
            wait_quiet(1500, ok);
            if (par_a != model_last) begin
                exp_q.push_back(par_a);
                model_last = par_a;
                wait_quiet(1500, ok);
            end
            n_tests++;
            if (!ok) begin n_fail++; $display("FAIL rand_timeout: iteration %0d never settled", it); end
        end
        n_tests++;
        if (a_words.size() - w0 !== exp_q.size()) begin
            n_fail++; $display("FAIL rand_count: got %0d want %0d", a_words.size() - w0, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (a_words[w0+i] !== exp_q[i]) begin
                n_fail++; $display("FAIL rand_word%0d: got %h want %h", i, a_words[w0+i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_transfer();
        test_clkdiv1();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        test_toggle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
